// File: rtl/dmem_arb.sv
// Data-memory arbiter: the CPU owns the single-port RAM whenever it is enabled.
// One DMA request at a time is held and slipped into the idle RAM slots.
`ifndef DMEM_MSB
`define DMEM_MSB 12
`endif

module dmem_arb #(
  parameter int ADDR_W     = `DMEM_MSB,
  parameter int STARVE_LIM = 64
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              cpu_cen,
  input  logic [1:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [1:0]        dma_be,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [15:0]       dma_wdata,
  output logic              dma_ready,
  output logic              dma_rvalid,
  output logic [15:0]       dma_rdata,
  output logic              dma_starve,
  output logic              ram_ena,
  output logic [1:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [15:0]       ram_dina,
  input  logic [15:0]       ram_douta
);

  typedef enum logic [1:0] {IDLE, PEND, RDRSP} state_t;

  state_t              state, state_nxt;
  logic                h_we;
  logic [1:0]          h_be;
  logic [ADDR_W-1:0]   h_addr;
  logic [15:0]         h_wdata;
  logic [7:0]          wait_cnt;
  logic                accept, issue;

  assign dma_ready  = (state == IDLE);
  assign accept     = dma_ready & dma_req;
  assign cpu_dout   = ram_douta;
  assign dma_starve = (wait_cnt >= 8'(STARVE_LIM));

  // RAM port mux: CPU first, then the held DMA access in PEND.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 2'b00;
    ram_addra = cpu_addr;
    ram_dina  = cpu_din;
    issue     = 1'b0;
    if (!cpu_cen) begin
      ram_ena = 1'b1;
      ram_wea = ~cpu_wen;
    end else if (state == PEND) begin
      ram_ena   = 1'b1;
      ram_wea   = h_we ? h_be : 2'b00;
      ram_addra = h_addr;
      ram_dina  = h_wdata;
      issue     = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PEND;
      PEND:    if (issue)  state_nxt = h_we ? IDLE : RDRSP;
      RDRSP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      h_we       <= 1'b0;
      h_be       <= 2'b00;
      h_addr     <= '0;
      h_wdata    <= 16'h0000;
      wait_cnt   <= 8'd0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= 16'h0000;
    end else begin
      state      <= state_nxt;
      dma_rvalid <= (state == RDRSP);
      // RAM output during RDRSP belongs to the DMA read issued the cycle before.
      if (state == RDRSP) dma_rdata <= ram_douta;
      if (accept) begin
        h_we    <= dma_we;
        h_be    <= dma_be;
        h_addr  <= dma_addr;
        h_wdata <= dma_wdata;
      end
      if (issue)
        wait_cnt <= 8'd0;
      else if (state == PEND && !cpu_cen && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a behavioural 1-cycle-latency byte-write RAM.
module tb_dmem_arb;
  localparam int AW = 8;

  logic          mclk = 1'b0;
  logic          reset_n;
  logic          cpu_cen;
  logic [1:0]    cpu_wen;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_din, cpu_dout;
  logic          dma_req, dma_we;
  logic [1:0]    dma_be;
  logic [AW-1:0] dma_addr;
  logic [15:0]   dma_wdata;
  logic          dma_ready, dma_rvalid, dma_starve;
  logic [15:0]   dma_rdata;
  logic          ram_ena;
  logic [1:0]    ram_wea;
  logic [AW-1:0] ram_addra;
  logic [15:0]   ram_dina, ram_douta;

  int checks = 0;
  int failures = 0;

  always #5 mclk = ~mclk;

  dmem_arb #(.ADDR_W(AW), .STARVE_LIM(4)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout),
    .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ready(dma_ready), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .dma_starve(dma_starve),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_douta(ram_douta)
  );

  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    ram_douta = 16'h0000;
  end
  always @(posedge mclk) begin
    if (ram_ena) begin
      if (ram_wea[0]) mem[ram_addra][7:0]  <= ram_dina[7:0];
      if (ram_wea[1]) mem[ram_addra][15:8] <= ram_dina[15:8];
      ram_douta <= mem[ram_addra];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [15:0] exp, input string tag);
    cpu_cen = 1'b0; cpu_wen = 2'b11; cpu_addr = a;
    tick();
    cpu_cen = 1'b1;
    #1 chk(tag, cpu_dout, exp);
  endtask

  task automatic dma_post(input logic we, input logic [1:0] be, input logic [AW-1:0] a,
                          input logic [15:0] d);
    dma_req = 1'b1; dma_we = we; dma_be = be; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    reset_n = 1'b0; cpu_cen = 1'b1; cpu_wen = 2'b11; cpu_addr = '0; cpu_din = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_be = 2'b00; dma_addr = '0; dma_wdata = '0;
    #12;
    chk("rst_ready", dma_ready, 1);
    chk("rst_rvalid", dma_rvalid, 0);
    chk("rst_rdata", dma_rdata, 16'h0000);
    chk("rst_starve", dma_starve, 0);
    chk("rst_ena", ram_ena, 0);
    @(negedge mclk); reset_n = 1'b1;
    tick();

    // DMA write, CPU idle
    dma_post(1'b1, 2'b11, 8'd5, 16'hA55A);
    #1 chk("wr_ready", dma_ready, 1);
    tick(); dma_req = 1'b0;
    chk("wr_busy", dma_ready, 0);
    chk("wr_ena", ram_ena, 1);
    chk("wr_wea", ram_wea, 2'b11);
    chk("wr_addr", ram_addra, 5);
    chk("wr_din", ram_dina, 16'hA55A);
    tick();
    chk("wr_idle", dma_ready, 1);
    cpu_read(8'd5, 16'hA55A, "wr_readback");

    // DMA read, CPU idle: rvalid in the third cycle after acceptance
    dma_post(1'b0, 2'b00, 8'd5, 16'h0000);
    tick(); dma_req = 1'b0;
    chk("rd_issue_wea", {ram_ena, ram_wea}, 3'b100);
    chk("rd_rvalid0", dma_rvalid, 0);
    tick();
    chk("rd_rvalid1", dma_rvalid, 0);
    tick();
    chk("rd_rvalid2", dma_rvalid, 1);
    chk("rd_rdata", dma_rdata, 16'hA55A);
    tick();
    chk("rd_rvalid_pulse", dma_rvalid, 0);
    chk("rd_idle", dma_ready, 1);

    // CPU contention for 10 cycles on a pending DMA write
    cpu_cen = 1'b0; cpu_wen = 2'b11; cpu_addr = 8'd0;
    dma_post(1'b1, 2'b11, 8'd9, 16'h1111);
    tick(); dma_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("cont_no_issue", {ram_wea, ram_addra}, {2'b00, 8'd0});
      tick();
    end
    chk("cont_cnt10", dut.wait_cnt, 10);
    chk("cont_starve", dma_starve, 1);
    cpu_cen = 1'b1;
    #1 chk("cont_issue", {ram_ena, ram_wea, ram_addra}, {1'b1, 2'b11, 8'd9});
    tick();
    chk("cont_cnt_clr", dut.wait_cnt, 0);
    chk("cont_ready", dma_ready, 1);
    cpu_read(8'd9, 16'h1111, "cont_readback");

    // Starvation flag with STARVE_LIM=4, CPU busy 6 cycles
    cpu_cen = 1'b0; cpu_wen = 2'b11; cpu_addr = 8'd1;
    dma_post(1'b1, 2'b01, 8'd10, 16'h2222);
    tick(); dma_req = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("starve_w%0d", i), dma_starve, (i >= 4) ? 1 : 0);
    end
    cpu_cen = 1'b1;
    #1 chk("starve_issue", {ram_ena, ram_wea}, 3'b101);
    tick();
    chk("starve_fall", dma_starve, 0);
    cpu_read(8'd10, 16'h0022, "starve_bytewr");

    // CPU write during RDRSP must not disturb the DMA read data
    dma_post(1'b0, 2'b00, 8'd5, 16'h0000);
    tick(); dma_req = 1'b0;
    tick();
    cpu_cen = 1'b0; cpu_wen = 2'b00; cpu_addr = 8'd7; cpu_din = 16'h1234;
    #1 chk("rdrsp_cpu_wr", {ram_wea, ram_addra}, {2'b11, 8'd7});
    tick(); cpu_cen = 1'b1;
    chk("rdrsp_rvalid", dma_rvalid, 1);
    chk("rdrsp_rdata", dma_rdata, 16'hA55A);
    cpu_read(8'd7, 16'h1234, "rdrsp_addr7");

    // Held write with no byte enables is a no-op slot
    dma_post(1'b1, 2'b00, 8'd5, 16'hFFFF);
    tick(); dma_req = 1'b0;
    chk("be0_slot", {ram_ena, ram_wea}, 3'b100);
    tick();
    chk("be0_done", dma_ready, 1);
    cpu_read(8'd5, 16'hA55A, "be0_unchanged");

    // Back-to-back acceptance on IDLE re-entry
    dma_post(1'b1, 2'b11, 8'd20, 16'h0BB0);
    tick();
    chk("b2b_pend", dma_ready, 0);
    dma_post(1'b1, 2'b11, 8'd21, 16'h0CC0);
    tick();
    chk("b2b_ready", dma_ready, 1);
    tick(); dma_req = 1'b0;
    chk("b2b_issue2", {ram_ena, ram_addra}, {1'b1, 8'd21});
    tick();

    // Reset while PEND drops the request
    cpu_cen = 1'b0; cpu_wen = 2'b11; cpu_addr = 8'd0;
    dma_post(1'b1, 2'b11, 8'd12, 16'hDEAD);
    tick(); dma_req = 1'b0;
    tick();
    chk("pend_cnt", dut.wait_cnt, 1);
    reset_n = 1'b0; cpu_cen = 1'b1;
    #1 chk("rstp_ready", dma_ready, 1);
    chk("rstp_ena", ram_ena, 0);
    chk("rstp_cnt", dut.wait_cnt, 0);
    tick();
    @(negedge mclk); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstp_no_rvalid", {dma_rvalid, ram_ena}, 2'b00);
    end
    cpu_read(8'd12, 16'h0000, "rstp_no_write");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default `DMEM_MSB, data-memory word-address width.
REQ-002 SHALL have parameter STARVE_LIM, default 64, DMA-wait cycle count that raises dma_starve (range 1..255).
REQ-003 SHALL have port mclk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cpu_cen, input, 1 bit: CPU data-memory chip enable, active low.
REQ-006 SHALL have port cpu_wen, input, 2 bits: CPU byte write enables, active low; 2'b11 means read.
REQ-007 SHALL have ports cpu_addr (input, ADDR_W bits) and cpu_din (input, 16 bits): CPU address and write data.
REQ-008 SHALL have port cpu_dout, output, 16 bits: CPU read data.
REQ-009 SHALL have ports dma_req (input, 1), dma_we (input, 1), dma_be (input, 2, active high), dma_addr (input, ADDR_W) and dma_wdata (input, 16): DMA request channel.
REQ-010 SHALL have port dma_ready, output, 1 bit: DMA request accepted when dma_req and dma_ready are both high on a rising edge.
REQ-011 SHALL have ports dma_rvalid (output, 1) and dma_rdata (output, 16): DMA read response.
REQ-012 SHALL have port dma_starve, output, 1 bit: DMA waited STARVE_LIM or more cycles.
REQ-013 SHALL have ports ram_ena (output, 1), ram_wea (output, 2, active high), ram_addra (output, ADDR_W), ram_dina (output, 16) and ram_douta (input, 16): port toward the single-port data RAM, which has 1-cycle read latency.

Function
REQ-014 SHALL implement FSM states IDLE, PEND and RDRSP.
REQ-015 SHALL drive dma_ready = 1 only in IDLE (combinational from state).
REQ-016 SHALL, on acceptance in IDLE, latch dma_we, dma_be, dma_addr and dma_wdata into holding registers and move to PEND.
REQ-017 SHALL give the CPU absolute priority: any cycle with cpu_cen=0 drives ram_ena=1, ram_wea=~cpu_wen, ram_addra=cpu_addr and ram_dina=cpu_din, with no added latency.
REQ-018 SHALL, in PEND with cpu_cen=1, issue the held DMA access that cycle: ram_ena=1, ram_addra and ram_dina from the holding registers, and ram_wea = held dma_be if held dma_we=1, else 2'b00.
REQ-019 SHALL, on a DMA issue, go PEND->IDLE for a write and PEND->RDRSP for a read.
REQ-020 SHALL, in PEND with cpu_cen=0, remain in PEND with no DMA issue.
REQ-021 SHALL, in RDRSP, register ram_douta into dma_rdata and assert dma_rvalid for exactly one cycle on the following cycle, then go to IDLE.
REQ-022 SHALL allow a CPU access during RDRSP, which is pipelined and does not corrupt the DMA read data.
REQ-023 SHALL drive cpu_dout = ram_douta continuously; CPU read data is valid the cycle after its access.
REQ-024 SHALL drive ram_ena=0, ram_wea=2'b00 and ram_addra/ram_dina from the CPU inputs when neither the CPU nor the DMA accesses the RAM.
REQ-025 SHALL ignore a held DMA write with dma_be=2'b00; it is issued as a no-op slot (ram_ena=1, ram_wea=0) and completes normally.
REQ-026 SHALL keep an 8-bit wait counter: increment each PEND cycle with cpu_cen=0, saturate at 255, clear on DMA issue.
REQ-027 SHALL assert dma_starve combinationally while the wait counter is at or above STARVE_LIM.
REQ-028 SHALL allow a new DMA acceptance in the cycle IDLE is re-entered, with no bubble beyond the FSM transition.

Reset
REQ-029 SHALL, on reset_n=0 (asynchronous), force state IDLE, dma_rvalid=0, dma_rdata=16'h0000, wait counter 0 and all holding registers 0.
REQ-030 SHALL drop any pending or in-flight DMA transfer on reset with no dma_rvalid produced; the CPU path stays combinational during reset.
REQ-031 SHALL release reset synchronously to mclk, with the first acceptance possible on the first rising edge after deassertion.

Verification
REQ-032 SHALL cover a DMA write with the CPU idle: dma_req=1, we=1, be=2'b11, addr=5, wdata=16'hA55A -> ram_ena=1, ram_wea=2'b11 one cycle after acceptance; a subsequent CPU read of addr 5 returns 16'hA55A.
REQ-033 SHALL cover a DMA read with the CPU idle: DMA read of addr 5 -> dma_rvalid pulses once, 3 cycles after acceptance, with dma_rdata=16'hA55A.
REQ-034 SHALL cover CPU contention: cpu_cen=0 for 10 cycles while a DMA write is pending -> no DMA issue during those cycles; issue on the first cpu_cen=1 cycle; wait counter reaches 10 then clears.
REQ-035 SHALL cover starvation: STARVE_LIM=4 and the CPU busy 6 cycles -> dma_starve rises on the 4th wait cycle and falls after issue.
REQ-036 SHALL cover a CPU access during RDRSP: CPU write of 16'h1234 to addr 7 in the RDRSP cycle -> DMA dma_rdata is unchanged and addr 7 holds 16'h1234.
REQ-037 SHALL cover reset while in PEND: reset_n=0 for 1 cycle -> dma_ready=1, no RAM write from the dropped request, no dma_rvalid.
